// File: rtl/console_uart_tx.sv
// console_uart_tx: MMIO console sink that queues stored bytes and sends them as UART 8N1
module console_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] FINI_CODE    = 32'h0002_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wvalid_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        full_o,
    output logic        tx_busy_o,
    output logic        overflow_o,
    output logic        fini_o,
    output logic        txd_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          txd, txd_n;
    logic          fini_pend, overflow, fini;
    logic          accept, is_fini, push_req, full, push, pop, tick;
    logic          unused_bits;

    assign unused_bits = ^addr_i[30:0];
    assign accept      = wvalid_i & addr_i[31] & ~fini_pend;
    assign is_fini     = wdata_i == FINI_CODE;
    assign push_req    = accept & ~is_fini;
    assign full        = count == (AW+1)'(FIFO_DEPTH);
    assign push        = push_req & ~full;
    assign tick        = cnt == '0;

    assign full_o      = full;
    assign tx_busy_o   = (count != '0) | (state != IDLE);
    assign overflow_o  = overflow;
    assign fini_o      = fini;
    assign txd_o       = txd;

    // Byte storage; holds no control state so it needs no reset
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata_i[7:0];
    end

    // FIFO pointers/count plus the sticky overflow and finish flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            fini_pend <= 1'b0;
            fini      <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow  <= overflow | (push_req & full);
            fini_pend <= fini_pend | (accept & is_fini);
            fini      <= fini | (fini_pend & (count == '0) & (state == IDLE));
        end
    end

    // Serialiser registers; txd lags the state by one cycle so every bit is a clean flop output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            txd     <= txd_n;
        end
    end

    // Frame sequencing: pop in IDLE, then start bit, 8 data bits LSB first, stop bit
    always_comb begin
        state_n = state;
        cnt_n   = tick ? CNT_MAX : cnt - 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        txd_n   = 1'b1;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    cnt_n   = CNT_MAX;
                    state_n = START;
                end
            end
            START: begin
                txd_n = 1'b0;
                if (tick) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                txd_n = shift[0];
                if (tick) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_idx + 3'd1;
                    state_n = (bit_idx == 3'd7) ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: randomized stores checked against a byte-queue model and a line-level UART receiver
module tb_console_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] FINI  = 32'h0002_0000;

    logic        clk_i = 1'b0, rst_ni = 1'b0, wvalid_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        full_o, tx_busy_o, overflow_o, fini_o, txd_o;

    int n_checks = 0, n_fail = 0, cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       ok;
        int         start;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         m_occ = 0;
    logic       m_ovf = 1'b0, m_pend = 1'b0;

    logic [FRAME-1:0] mon_s;
    logic             mon_ab;
    int               mon_st;
    rx_t              mon_r;

    console_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FINI_CODE(FINI)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wvalid_i(wvalid_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .full_o(full_o), .tx_busy_o(tx_busy_o), .overflow_o(overflow_o), .fini_o(fini_o), .txd_o(txd_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Line receiver: every bit must hold for CPB samples, start=0, stop=1
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_ni && txd_o == 1'b0) begin
                mon_st = cyc;
                mon_ab = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) begin
                        @(posedge clk_i);
                        #2;
                    end
                    if (!rst_ni) begin
                        mon_ab = 1'b1;
                        break;
                    end
                    mon_s[i] = txd_o;
                end
                if (!mon_ab) begin
                    mon_r.ok    = (mon_s[0] == 1'b0) && (mon_s[9*CPB] == 1'b1);
                    mon_r.start = mon_st;
                    for (int b = 0; b < 10; b++)
                        for (int c = 0; c < CPB; c++)
                            if (mon_s[b*CPB+c] != mon_s[b*CPB]) mon_r.ok = 1'b0;
                    for (int j = 0; j < 8; j++) mon_r.data[j] = mon_s[(j+1)*CPB];
                    rx_q.push_back(mon_r);
                end
            end
        end
    end

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        if (a[31] && !m_pend) begin
            if (d == FINI) m_pend = 1'b1;
            else if (m_occ < DEPTH) begin
                exp_q.push_back(d[7:0]);
                m_occ++;
            end else m_ovf = 1'b1;
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, output int acc);
        wvalid_i = 1'b1;
        addr_i   = a;
        wdata_i  = d;
        model_store(a, d);
        step();
        wvalid_i = 1'b0;
        acc      = cyc;
    endtask

    task automatic expect_rx(input string tag, input int ref_c, input int gap, output int st);
        int   w = 0;
        rx_t  r;
        st = ref_c + gap;
        while (rx_q.size() == 0 && w < 200) begin
            step();
            w++;
        end
        if (rx_q.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
            return;
        end
        r  = rx_q.pop_front();
        st = r.start;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected"}, {24'h0, r.data}, 32'hffff_ffff);
            return;
        end
        check({tag, "_byte"}, {24'h0, r.data}, {24'h0, exp_q.pop_front()});
        check({tag, "_frame"}, {31'h0, r.ok}, 1);
        check({tag, "_gap"}, r.start - ref_c, gap);
    endtask

    task automatic do_reset();
        wvalid_i = 1'b0;
        rst_ni   = 1'b0;
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        rx_q.delete();
        exp_q.delete();
        m_occ  = 0;
        m_ovf  = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_txd"}, {31'h0, txd_o}, 1);
        check({tag, "_full"}, {31'h0, full_o}, 0);
        check({tag, "_busy"}, {31'h0, tx_busy_o}, 0);
        check({tag, "_ovf"}, {31'h0, overflow_o}, 0);
        check({tag, "_fini"}, {31'h0, fini_o}, 0);
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] v = $urandom;
        return (v == FINI) ? v ^ 32'h1 : v;
    endfunction

    initial begin
        int          a0, a1, s, fc;
        logic [31:0] wd;
        logic [7:0]  d;
        bit          hi;

        do_reset();
        check_quiet("reset");

        for (int i = 0; i < 4; i++) begin
            wd = (i == 0) ? 32'h41 : rand_data();
            store((i == 0) ? 32'h8000_0000 : (32'h8000_0000 | $urandom), wd, a0);
            m_occ--;
            check("t1_busy_start", {31'h0, tx_busy_o}, 1);
            expect_rx("t1", a0, 2, s);
            check("t1_busy_end", {31'h0, tx_busy_o}, 0);
        end

        do_reset();
        for (int i = 0; i < 4; i++) store((i == 0) ? 32'h0000_1000 : ($urandom & 32'h7fff_ffff), (i == 0) ? 32'h41 : rand_data(), a0);
        hi = 1'b1;
        repeat (100) begin
            hi &= txd_o & ~tx_busy_o & ~full_o;
            step();
        end
        check("t2_line_idle", {31'h0, hi}, 1);
        check("t2_no_rx", rx_q.size(), 0);

        do_reset();
        d = 8'($urandom_range(0, 250));
        for (int i = 0; i < 6; i++) begin
            store(32'h8000_0000 | $urandom, {24'($urandom), d + 8'(i)}, a1);
            if (i == 0) begin
                a0 = a1;
                m_occ--;
            end
        end
        check("t3_full", {31'h0, full_o}, {31'h0, m_occ == DEPTH});
        check("t3_ovf", {31'h0, overflow_o}, {31'h0, m_ovf});
        expect_rx("t3_0", a0, 2, s);
        for (int i = 1; i < 5; i++) expect_rx($sformatf("t3_%0d", i), s, FRAME + 1, s);
        check("t3_drained", exp_q.size(), 0);
        repeat (50) step();
        check("t3_no_extra", rx_q.size(), 0);
        check("t3_busy_end", {31'h0, tx_busy_o}, 0);

        do_reset();
        store(32'h8000_0000, 32'h48, a0);
        m_occ--;
        store(32'h8000_0000, 32'h69, a1);
        store(32'h8000_0000, FINI, a1);
        check("t4_fini_early", {31'h0, fini_o}, 0);
        fc = -1;
        for (int w = 0; w < 300; w++) begin
            if (fini_o) begin
                fc = cyc;
                break;
            end
            step();
        end
        check("t4_fini_seen", {31'h0, fini_o}, 1);
        expect_rx("t4_h", a0, 2, s);
        expect_rx("t4_i", s, FRAME + 1, s);
        check("t4_fini_time", fc - s, FRAME);
        store(32'h8000_0000, 32'h55, a1);
        hi = 1'b1;
        repeat (60) begin
            hi &= txd_o & ~tx_busy_o & fini_o & ~overflow_o;
            step();
        end
        check("t4_ignored", {31'h0, hi}, 1);
        check("t4_no_rx", rx_q.size(), 0);

        do_reset();
        d = 8'($urandom) & 8'hf7;
        store(32'h8000_0000, {24'h0, d}, a0);
        repeat (18) step();
        check("t5_in_bit3", {31'h0, txd_o}, 0);
        #2 rst_ni = 1'b0;
        #1 check_quiet("t5_async");
        repeat (2) step();
        rst_ni = 1'b1;
        step();
        rx_q.delete();
        exp_q.delete();
        m_occ = 0;
        check_quiet("t5_release");
        store(32'h8000_0000, 32'h5a, a0);
        m_occ--;
        expect_rx("t5_after", a0, 2, s);

        do_reset();
        store(32'h8000_0000, rand_data(), a0);
        m_occ--;
        store(32'h8000_0000, rand_data(), a1);
        store(32'h8000_0000, rand_data(), a1);
        while (cyc < a0 + FRAME + 1) step();
        m_occ--;
        store(32'h8000_0000, rand_data(), a1);
        check("t6_full_d", {31'h0, full_o}, {31'h0, m_occ == DEPTH});
        store(32'h8000_0000, rand_data(), a1);
        check("t6_full_e", {31'h0, full_o}, {31'h0, m_occ == DEPTH});
        store(32'h8000_0000, rand_data(), a1);
        check("t6_full_f", {31'h0, full_o}, {31'h0, m_occ == DEPTH});
        check("t6_ovf", {31'h0, overflow_o}, {31'h0, m_ovf});
        expect_rx("t6_0", a0, 2, s);
        for (int i = 1; i < 6; i++) expect_rx($sformatf("t6_%0d", i), s, FRAME + 1, s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
